inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Write-side counterpart to the instruction memory's combinational read port.
- Accepts a byte stream (e.g. from a UART/debug bridge) carrying a 16-bit little-endian word count followed by the program image.
- Assembles each group of 4 bytes into a little-endian 32-bit instruction and drives a one-cycle write strobe into the instruction memory write port at consecutive word-aligned byte addresses starting at 0.
- Asserts busy while loading; this holds the CPU in reset.

Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32; a 4-byte assembly is assumed.
- ADDR_WIDTH, 32, width of mem_addr (byte address).
- MEM_SIZE, 512, capacity of instruction memory in words; the largest legal word count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that arms a new load; honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte; transfer occurs when byte_valid && byte_ready at the rising edge.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  ADDR_WIDTH  byte address of the write; always word-aligned (bits [1:0] = 0).
- mem_wdata  out  DATA_WIDTH  instruction word.
- busy  out  1  load in progress (LEN_LO, LEN_HI or DATA).
- done  out  1  level; last load completed successfully.
- error  out  1  level; last load was rejected.
- words_written  out  16  count of words written in the current or last load.

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_written=0, state=IDLE, byte index=0, length register=0.
- State IDLE:
  - byte_ready=0.
  - start -> LEN_LO; clears done, error and words_written.
- State LEN_LO:
  - byte_ready=1.
  - On accept: len[7:0]=byte_data -> LEN_HI.
- State LEN_HI:
  - byte_ready=1.
  - On accept: len[15:8]=byte_data.
  - Full length is 0 -> DONE.
  - Full length > MEM_SIZE -> ERR.
  - Otherwise -> DATA.
- State DATA:
  - byte_ready=1.
  - Bytes are placed at lanes [7:0], [15:8], [23:16] and [31:24] in arrival order.
  - The accept of the 4th byte registers the write: in the next cycle mem_we=1, mem_wdata=assembled word, mem_addr=words_written_old<<2, and words_written increments. Write latency is 1 cycle after the 4th byte handshake.
  - If this was word len-1, the state goes to DONE on the same edge, so done and the final mem_we rise in the same cycle.
- State DONE:
  - byte_ready=0, done=1.
  - start -> LEN_LO.
- State ERR:
  - byte_ready=0, error=1, no memory writes.
  - start -> LEN_LO.
- Timing and strobes:
  - Back-to-back bytes are accepted with no bubbles, so the peak rate is one write every 4 cycles.
  - mem_we is never asserted for 2 consecutive cycles.
  - byte_valid low stalls the loader indefinitely with no timeout.
- start is ignored while busy=1.
- start and a byte in the same cycle in DONE/ERR: start is taken; the byte is not accepted because byte_ready=0.
- Reset mid-load:
  - All state returns to IDLE, and a partially assembled word is discarded.
  - Words already written stay in memory.
  - A write registered on the edge coinciding with reset assertion is dropped.
- Word count width: len is 16-bit unsigned, and MEM_SIZE=512 is the maximum accepted length.
- mem_addr wraps never: the MEM_SIZE check guarantees the highest address is (MEM_SIZE-1)*4.

Decomposition:
- Package inst_loader_pkg holds:
  - the typedef enum logic [2:0] loader_state_t {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR};
  - localparam BYTES_PER_WORD=4;
  - localparam LEN_WIDTH=16.
- Sub-module byte_assembler:
  - Inputs: clk, rst, clear, byte_in_valid, byte_in[7:0].
  - Outputs: word_out[31:0], word_valid (1-cycle pulse on the 4th byte).
  - Holds a 2-bit lane counter and a 32-bit shift/lane register.
  - The top FSM drives clear on entry to LEN_LO.

Test Plan:
- Normal load:
  - Stimulus: start, bytes 02 00, then 13 05 10 00, then 93 05 20 00, back-to-back.
  - Expect two mem_we pulses: addr 0x0 / data 0x00100513, then addr 0x4 / data 0x00200593.
  - Then done=1, words_written=2, busy=0.
- Zero length:
  - Stimulus: start, bytes 00 00.
  - Expect DONE the cycle after the 2nd byte, no mem_we, done=1, words_written=0.
- Oversize:
  - Stimulus: start, bytes 01 02 (len=513).
  - Expect error=1, byte_ready=0 and no mem_we.
  - A subsequent start followed by a valid 1-word stream succeeds: error cleared, done=1.
- Stalls:
  - Stimulus: same stream as the normal load with byte_valid deasserted for 3 random cycles between every byte.
  - Expect identical writes, and the start pulse mid-load has no effect.
- Reset mid-word:
  - Stimulus: start, len=1, two data bytes, then assert rst.
  - Expect all outputs at reset values and no mem_we.
  - A reload of len=1 with AA BB CC DD writes 0xDDCCBBAA at addr 0.
- Boundary:
  - Stimulus: len=512 with random data.
  - Expect 512 writes, last at addr 0x7FC, done=1, and no back-to-back mem_we.

Source files
------------

// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inst_loader_pkg
// Brief   : Shared state encoding and sizing constants for the instruction loader.
// Rev     : 1.0
// ============================================================================
package inst_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_LO = 3'd1,
      LEN_HI = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } loader_state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_WIDTH      = 16;

endpackage
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : inst_loader_if
// Brief   : Byte-stream input and instruction-memory write port of the loader.
// Rev     : 1.0
// ============================================================================
interface inst_loader_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // master is the loader; slave is the byte source plus the memory
   modport master (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/inst_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module  : byte_assembler
// Brief   : Packs four accepted bytes little-endian into a 32-bit word.
// Rev     : 1.0
// ============================================================================
module byte_assembler
   import inst_loader_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        clear,
   input  wire logic        byte_in_valid,
   input  wire logic [7:0]  byte_in,
   output logic      [31:0] word_out,
   output logic             word_valid
);
   localparam int c_lane_w = $clog2(BYTES_PER_WORD);

   logic [c_lane_w-1:0] r_lane;
   logic [23:0]         r_word;

   // the fourth byte bypasses the register so the word is usable on its accept edge
   assign word_valid = byte_in_valid && (r_lane == c_lane_w'(BYTES_PER_WORD - 1));
   assign word_out   = {byte_in, r_word};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (clear) begin
         r_lane <= '0;
         r_word <= '0;
      end else if (byte_in_valid) begin
         case (r_lane)
            2'd0:    r_word[7:0]   <= byte_in;
            2'd1:    r_word[15:8]  <= byte_in;
            2'd2:    r_word[23:16] <= byte_in;
            default: r_word        <= r_word;
         endcase
         r_lane <= r_lane + c_lane_w'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module  : inst_loader
// Brief   : Loads a length-prefixed byte stream into instruction memory.
// Rev     : 1.0
// ============================================================================
module inst_loader
   import inst_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_SIZE   = 512
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 start,
   inst_loader_if.master             bus,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic [LEN_WIDTH-1:0]      words_written
);
   localparam logic [LEN_WIDTH-1:0] c_max_len = LEN_WIDTH'(MEM_SIZE);

   loader_state_t        r_state;
   logic [LEN_WIDTH-1:0] r_len;

   logic                 w_accept;
   logic                 w_start_ok;
   logic [LEN_WIDTH-1:0] w_full_len;
   logic                 w_last;
   logic [31:0]          w_word;
   logic                 w_word_valid;

   assign w_accept   = bus.byte_valid && bus.byte_ready;
   assign w_start_ok = start && (r_state == IDLE || r_state == DONE || r_state == ERR);
   assign w_full_len = {bus.byte_data, r_len[7:0]};
   assign w_last     = (words_written == (r_len - LEN_WIDTH'(1)));

   byte_assembler u_asm (
      .clk           (clk),
      .rst           (rst),
      .clear         (w_start_ok),
      .byte_in_valid (w_accept && (r_state == DATA)),
      .byte_in       (bus.byte_data),
      .word_out      (w_word),
      .word_valid    (w_word_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_len          <= '0;
         bus.byte_ready <= 1'b0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         words_written  <= '0;
      end else begin
         bus.mem_we <= 1'b0;
         case (r_state)
            IDLE, DONE, ERR: begin
               if (w_start_ok) begin
                  r_state        <= LEN_LO;
                  r_len          <= '0;
                  bus.byte_ready <= 1'b1;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  error          <= 1'b0;
                  words_written  <= '0;
               end
            end
            LEN_LO: begin
               if (w_accept) begin
                  r_len[7:0] <= bus.byte_data;
                  r_state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (w_accept) begin
                  r_len[15:8] <= bus.byte_data;
                  if (w_full_len == '0) begin
                     r_state        <= DONE;
                     bus.byte_ready <= 1'b0;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                  end else if (w_full_len > c_max_len) begin
                     r_state        <= ERR;
                     bus.byte_ready <= 1'b0;
                     busy           <= 1'b0;
                     error          <= 1'b1;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_word_valid) begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_wdata <= DATA_WIDTH'(w_word);
                  bus.mem_addr  <= ADDR_WIDTH'({words_written, 2'b00});
                  words_written <= words_written + LEN_WIDTH'(1);
                  // final word: done rises together with its write strobe
                  if (w_last) begin
                     r_state        <= DONE;
                     bus.byte_ready <= 1'b0;
                     busy           <= 1'b0;
                     done           <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_inst_loader
// Brief   : Scoreboard bench for inst_loader with directed byte streams.
// Rev     : 1.0
// ============================================================================
module tb_inst_loader;
   logic        clk;
   logic        rst;
   logic        start;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_written;

   int n_vec;
   int n_err;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t  exp_q[$];
   logic prev_we;

   inst_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   inst_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_written (words_written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor: pops the scoreboard on every strobe
   always @(negedge clk) begin
      wr_t e;
      if (bus.mem_we === 1'b1) begin
         n_vec++;
         if (prev_we === 1'b1) begin
            n_err++;
            $display("FAIL b2b_we: mem_we high two cycles in a row at addr %h", bus.mem_addr);
         end
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_we: got addr %h data %h, required no write", bus.mem_addr, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
               n_err++;
               $display("FAIL write: got addr %h data %h, required addr %h data %h",
                        bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end
         end
      end
      prev_we = bus.mem_we;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic seen;
      int   t;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      t = 0;
      do begin
         @(negedge clk);
         seen = bus.byte_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!seen && t < 50);
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL byte_timeout: got byte_ready 0 for 50 cycles, required 1 (byte %h)", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic idle(input int n);
      bus.byte_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   logic [31:0] w;

   initial begin
      n_vec = 0;
      n_err = 0;
      prev_we = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'h00;

      // reset state
      repeat (3) @(posedge clk);
      sample();
      check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
      check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      check("rst_mem_addr", bus.mem_addr, 32'd0);
      check("rst_mem_wdata", bus.mem_wdata, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_words", {16'd0, words_written}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // normal back-to-back load
      expect_wr(32'h0, 32'h0010_0513);
      expect_wr(32'h4, 32'h0020_0593);
      pulse_start();
      check("norm_busy", {31'd0, busy}, 32'd1);
      check("norm_ready", {31'd0, bus.byte_ready}, 32'd1);
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0010_0513);
      send_word(32'h0020_0593);
      bus.byte_valid = 1'b0;
      sample();
      check("norm_done", {31'd0, done}, 32'd1);
      check("norm_busy_end", {31'd0, busy}, 32'd0);
      check("norm_words", {16'd0, words_written}, 32'd2);
      check("norm_ready_end", {31'd0, bus.byte_ready}, 32'd0);
      check("norm_pending", exp_q.size(), 32'd0);

      // zero length
      idle(2);
      pulse_start();
      check("zero_done_cleared", {31'd0, done}, 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      bus.byte_valid = 1'b0;
      sample();
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_words", {16'd0, words_written}, 32'd0);
      check("zero_busy", {31'd0, busy}, 32'd0);

      // oversize length 513, then recovery
      idle(2);
      pulse_start();
      send_byte(8'h01); send_byte(8'h02);
      bus.byte_valid = 1'b0;
      sample();
      check("over_error", {31'd0, error}, 32'd1);
      check("over_ready", {31'd0, bus.byte_ready}, 32'd0);
      check("over_done", {31'd0, done}, 32'd0);
      idle(2);
      expect_wr(32'h0, 32'h1234_5678);
      pulse_start();
      check("recov_error_clr", {31'd0, error}, 32'd0);
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h1234_5678);
      bus.byte_valid = 1'b0;
      sample();
      check("recov_done", {31'd0, done}, 32'd1);
      check("recov_error", {31'd0, error}, 32'd0);
      check("recov_words", {16'd0, words_written}, 32'd1);

      // stalled stream with a start pulse mid-load
      idle(2);
      expect_wr(32'h0, 32'h0010_0513);
      expect_wr(32'h4, 32'h0020_0593);
      pulse_start();
      send_byte(8'h02); idle(3);
      send_byte(8'h00); idle(3);
      w = 32'h0010_0513;
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         idle(3);
      end
      pulse_start();
      check("stall_start_ign_busy", {31'd0, busy}, 32'd1);
      check("stall_start_ign_words", {16'd0, words_written}, 32'd1);
      w = 32'h0020_0593;
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         idle(3);
      end
      check("stall_done", {31'd0, done}, 32'd1);
      check("stall_words", {16'd0, words_written}, 32'd2);
      check("stall_pending", exp_q.size(), 32'd0);

      // reset in the middle of a word, then reload
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h11); send_byte(8'h22);
      bus.byte_valid = 1'b0;
      rst = 1'b1;
      sample();
      check("mid_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_we", {31'd0, bus.mem_we}, 32'd0);
      check("mid_rst_addr", bus.mem_addr, 32'd0);
      check("mid_rst_words", {16'd0, words_written}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      expect_wr(32'h0, 32'hDDCC_BBAA);
      pulse_start();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      bus.byte_valid = 1'b0;
      sample();
      check("reload_we_lat", {31'd0, bus.mem_we}, 32'd1);
      check("reload_done_with_we", {31'd0, done}, 32'd1);
      check("reload_pending", exp_q.size(), 32'd0);

      // maximum length: 512 words
      idle(2);
      pulse_start();
      send_byte(8'h00); send_byte(8'h02);
      for (int i = 0; i < 512; i++) begin
         w = $urandom;
         expect_wr(32'(i) << 2, w);
         send_word(w);
      end
      bus.byte_valid = 1'b0;
      sample();
      check("max_done", {31'd0, done}, 32'd1);
      check("max_words", {16'd0, words_written}, 32'd512);
      check("max_last_addr", bus.mem_addr, 32'h7FC);
      check("max_error", {31'd0, error}, 32'd0);
      idle(2);
      check("max_pending", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
